trig_sequencer: RTL and testbench
=================================

TRIG_SEQUENCER -- requirements
Module: trig_sequencer

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
  N_CH, 2, number of output trigger channels.
  CTR_W, 4, phase counter width; divide ratio up to 2^CTR_W.
  HO_W, 8, holdoff counter width.
  PC_W, 16, pulse counter width.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
  clk  in  1  system clock; one clock domain only.
  rst  in  1  asynchronous reset, active-high.
  trig_ext  in  1  external trigger, asynchronous.
  trig_int  in  1  internal trigger, synchronous to clk.
  trig_int_en  in  1  selects trig_int over trig_ext, asynchronous level.
  run  in  1  enables outputs, asynchronous level.
  trig_rdy  in  1  DAQ ready, asynchronous; a rising edge unblocks.
  trig_blk  in  1  blocking mode enable, asynchronous level.
  empty_trig_blk  in  1  low: every trigger goes to trig_out; high: only the selected phase goes, asynchronous level.
  trig_max_cnt  in  CTR_W  phase terminal count (ratio = value+1), asynchronous quasi-static.
  trig_seq_sel  in  N_CH*CTR_W  per-channel selected phase; channel i uses slice i, asynchronous quasi-static.
  holdoff  in  HO_W  re-arm holdoff in clk cycles, asynchronous quasi-static.
  pulse_ctr_rst  in  1  clears pulse_ctr, asynchronous, active-high.
  trig_out  out  N_CH  per-channel DAQ trigger pulse.
  trig_strb  out  N_CH  per-channel feedback/feedforward strobe.
  phase  out  CTR_W  current phase counter.
  pulse_ctr  out  PC_W  accepted trigger edge count.
  pile_up  out  1  trigger arrived while DAQ not ready.

Function
REQ-003 Each asynchronous input SHALL pass through a 2-flop synchroniser; trig_ext SHALL additionally get one IOB input register before its synchroniser.
REQ-004 A rising edge of the selected trigger source SHALL produce a 1-cycle internal edge pulse; trig_out and trig_strb SHALL be asserted exactly 5 clk edges after trig_ext is first sampled high (external source) and 2 clk edges after trig_int rises (internal source).
REQ-005 On each internal edge, phase SHALL increment; it SHALL wrap to 0 when phase >= trig_max_cnt (so a lowered trig_max_cnt takes effect on the next edge).
REQ-006 For channel i: trig_strb[i] = edge AND (phase == sel_i); trig_out[i] = edge AND (~empty_trig_blk OR phase == sel_i); both SHALL be 1-cycle registered pulses.
REQ-007 Gating FSM with states ARMED and BLOCKED: trig_out and trig_strb SHALL be forced to 0 while the FSM is BLOCKED or run is low; phase and pulse_ctr SHALL still advance.
REQ-008 ARMED->BLOCKED when any trig_out bit is asserted and trig_blk is high; BLOCKED->ARMED on a rising edge of synchronised trig_rdy; if both occur in the same cycle, the unblock SHALL win.
REQ-009 pile_up SHALL be updated on each edge to NOT trig_rdy (synchronised) and SHALL hold otherwise.
REQ-010 pulse_ctr SHALL increment on each edge and wrap from 2^PC_W-1 to 0; when synchronised pulse_ctr_rst and an edge coincide, the clear SHALL win.

Reset
REQ-011 While rst is high, every register SHALL be 0 and the FSM SHALL be ARMED; all outputs SHALL read 0. A reset asserted mid-holdoff or while BLOCKED SHALL abort that state.

Configuration
REQ-012 With TRIG_HOLDOFF_EN defined, edges arriving within holdoff cycles after an accepted edge SHALL be suppressed, with no effect on phase, pulse_ctr or the outputs; holdoff=0 SHALL mean no suppression.
REQ-013 Without TRIG_HOLDOFF_EN, the holdoff port SHALL be ignored, and every source edge SHALL be accepted.

Structure
REQ-014 Package trig_pkg SHALL hold the FSM state type and the parameter defaults.
REQ-015 A sub-module sync_bit (parametrised-width 2-flop synchroniser with an async reset) SHALL be instantiated for each asynchronous input.

Verification
REQ-016 The bench SHALL cover these scenarios:
  Case 1: trig_max_cnt=2, sel={1,0}, empty_trig_blk=1, 6 edges: strb[0] on edges 1 and 4, strb[1] on edges 2 and 5; pulse_ctr=6.
  Case 2: empty_trig_blk=0, 3 edges: trig_out=2'b11 on every edge; trig_strb only on matching phases.
  Case 3: trig_blk=1, first edge then 2 more edges with no trig_rdy: only the first trig_out is seen. Then pulse trig_rdy: the next edge passes.
  Case 4: TRIG_HOLDOFF_EN with holdoff=10, edges 5 cycles apart: the second edge is dropped and pulse_ctr=1. With edges 12 apart, both are counted.
  Case 5: pulse_ctr=2^PC_W-1 plus one edge: the counter reads 0. pulse_ctr_rst coinciding with an edge gives 0.
  Case 6: rst asserted while BLOCKED at phase=3: all outputs are 0 immediately; after release, the first edge passes with phase going to 1.

Source files
------------

// File: rtl/trig_pkg.sv
// Shared types and parameter defaults for the trigger sequencer.
// The optional re-arm holdoff is enabled by defining TRIG_HOLDOFF_EN.
package trig_pkg;

  localparam int DEF_N_CH  = 2;
  localparam int DEF_CTR_W = 4;
  localparam int DEF_HO_W  = 8;
  localparam int DEF_PC_W  = 16;

  typedef enum logic {
    ST_ARMED   = 1'b0,
    ST_BLOCKED = 1'b1
  } gate_state_t;

endpackage

// File: rtl/sync_bit.sv
// Two-flop synchroniser of parametrised width with asynchronous active-high reset.
// Multi-bit use is only for quasi-static configuration buses.
module sync_bit #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/trig_sequencer.sv
// Trigger sequencer: divides a trigger stream into phases and fans it out per channel,
// with DAQ-ready blocking. Define TRIG_HOLDOFF_EN to enable the re-arm holdoff.
module trig_sequencer
  import trig_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CTR_W = DEF_CTR_W,
  parameter int HO_W  = DEF_HO_W,
  parameter int PC_W  = DEF_PC_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trig_ext,
  input  logic                  trig_int,
  input  logic                  trig_int_en,
  input  logic                  run,
  input  logic                  trig_rdy,
  input  logic                  trig_blk,
  input  logic                  empty_trig_blk,
  input  logic [CTR_W-1:0]      trig_max_cnt,
  input  logic [N_CH*CTR_W-1:0] trig_seq_sel,
  input  logic [HO_W-1:0]       holdoff,
  input  logic                  pulse_ctr_rst,
  output logic [N_CH-1:0]       trig_out,
  output logic [N_CH-1:0]       trig_strb,
  output logic [CTR_W-1:0]      phase,
  output logic [PC_W-1:0]       pulse_ctr,
  output logic                  pile_up
);

  logic                  ext_iob;
  logic                  ext_s;
  logic                  int_en_s;
  logic                  run_s;
  logic                  rdy_s;
  logic                  blk_s;
  logic                  empty_s;
  logic                  pc_rst_s;
  logic [CTR_W-1:0]      max_s;
  logic [N_CH*CTR_W-1:0] sel_s;

  logic                  src;
  logic                  src_prev;
  logic                  src_rise;
  logic                  accept;
  logic                  edge_q;
  logic                  rdy_prev;
  logic                  rdy_rise;
  logic                  gate_open;
  logic [N_CH-1:0]       hit;
  logic [N_CH-1:0]       out_next;
  gate_state_t           state;

  // Input register in the pad ring ahead of the external trigger synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ext_iob <= 1'b0;
    else     ext_iob <= trig_ext;
  end

  sync_bit #(.W(1))          u_sync_ext    (.clk(clk), .rst(rst), .d(ext_iob),        .q(ext_s));
  sync_bit #(.W(1))          u_sync_int_en (.clk(clk), .rst(rst), .d(trig_int_en),    .q(int_en_s));
  sync_bit #(.W(1))          u_sync_run    (.clk(clk), .rst(rst), .d(run),            .q(run_s));
  sync_bit #(.W(1))          u_sync_rdy    (.clk(clk), .rst(rst), .d(trig_rdy),       .q(rdy_s));
  sync_bit #(.W(1))          u_sync_blk    (.clk(clk), .rst(rst), .d(trig_blk),       .q(blk_s));
  sync_bit #(.W(1))          u_sync_empty  (.clk(clk), .rst(rst), .d(empty_trig_blk), .q(empty_s));
  sync_bit #(.W(1))          u_sync_pc_rst (.clk(clk), .rst(rst), .d(pulse_ctr_rst),  .q(pc_rst_s));
  sync_bit #(.W(CTR_W))      u_sync_max    (.clk(clk), .rst(rst), .d(trig_max_cnt),   .q(max_s));
  sync_bit #(.W(N_CH*CTR_W)) u_sync_sel    (.clk(clk), .rst(rst), .d(trig_seq_sel),   .q(sel_s));

  assign src      = int_en_s ? trig_int : ext_s;
  assign src_rise = src & ~src_prev;
  assign rdy_rise = rdy_s & ~rdy_prev;

`ifdef TRIG_HOLDOFF_EN
  logic [HO_W-1:0] ho_s;
  logic [HO_W-1:0] ho_cnt;

  sync_bit #(.W(HO_W)) u_sync_ho (.clk(clk), .rst(rst), .d(holdoff), .q(ho_s));

  // Edges are dropped while the counter drains; a zero holdoff never blocks.
  assign accept = src_rise & (ho_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 ho_cnt <= '0;
    else if (accept)         ho_cnt <= ho_s;
    else if (ho_cnt != '0)   ho_cnt <= ho_cnt - 1'b1;
  end
`else
  logic holdoff_unused;
  assign holdoff_unused = ^holdoff;
  assign accept         = src_rise;
`endif

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      hit[i] = (phase == sel_s[i*CTR_W +: CTR_W]);
    end
    out_next = empty_s ? hit : '1;
  end

  assign gate_open = (state == ST_ARMED) && run_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_prev  <= 1'b0;
      rdy_prev  <= 1'b0;
      edge_q    <= 1'b0;
      trig_out  <= '0;
      trig_strb <= '0;
      phase     <= '0;
      pulse_ctr <= '0;
      pile_up   <= 1'b0;
      state     <= ST_ARMED;
    end else begin
      src_prev  <= src;
      rdy_prev  <= rdy_s;
      edge_q    <= accept;
      trig_out  <= (edge_q && gate_open) ? out_next : '0;
      trig_strb <= (edge_q && gate_open) ? hit : '0;

      // Compare against the live terminal count so a lowered value wraps at once.
      if (edge_q) begin
        phase   <= (phase >= max_s) ? '0 : phase + 1'b1;
        pile_up <= ~rdy_s;
      end

      if (pc_rst_s)    pulse_ctr <= '0;
      else if (edge_q) pulse_ctr <= pulse_ctr + 1'b1;

      // A ready edge in the same cycle as a blocking trigger keeps the gate open.
      case (state)
        ST_ARMED:   if (!rdy_rise && (|trig_out) && blk_s) state <= ST_BLOCKED;
        ST_BLOCKED: if (rdy_rise) state <= ST_ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_trig_sequencer.sv
// Directed bench for trig_sequencer: phase fan-out, blocking, run gating, latency,
// counter wrap/clear, holdoff (when TRIG_HOLDOFF_EN is defined) and reset abort.
module tb_trig_sequencer;

  localparam int N_CH  = 2;
  localparam int CTR_W = 4;
  localparam int HO_W  = 8;
  localparam int PC_W  = 8;

  logic                  clk;
  logic                  rst;
  logic                  trig_ext;
  logic                  trig_int;
  logic                  trig_int_en;
  logic                  run;
  logic                  trig_rdy;
  logic                  trig_blk;
  logic                  empty_trig_blk;
  logic [CTR_W-1:0]      trig_max_cnt;
  logic [N_CH*CTR_W-1:0] trig_seq_sel;
  logic [HO_W-1:0]       holdoff;
  logic                  pulse_ctr_rst;
  logic [N_CH-1:0]       trig_out;
  logic [N_CH-1:0]       trig_strb;
  logic [CTR_W-1:0]      phase;
  logic [PC_W-1:0]       pulse_ctr;
  logic                  pile_up;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0] o;
  logic [1:0] s;
  logic [1:0] exp_s1 [6] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
  logic [1:0] exp_s2 [3] = '{2'b01, 2'b10, 2'b00};

  trig_sequencer #(
    .N_CH(N_CH), .CTR_W(CTR_W), .HO_W(HO_W), .PC_W(PC_W)
  ) dut (
    .clk(clk), .rst(rst), .trig_ext(trig_ext), .trig_int(trig_int),
    .trig_int_en(trig_int_en), .run(run), .trig_rdy(trig_rdy), .trig_blk(trig_blk),
    .empty_trig_blk(empty_trig_blk), .trig_max_cnt(trig_max_cnt),
    .trig_seq_sel(trig_seq_sel), .holdoff(holdoff), .pulse_ctr_rst(pulse_ctr_rst),
    .trig_out(trig_out), .trig_strb(trig_strb), .phase(phase),
    .pulse_ctr(pulse_ctr), .pile_up(pile_up)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One internal trigger pulse; outputs land two edges after the rise.
  task automatic fire(output logic [1:0] out_v, output logic [1:0] strb_v);
    @(negedge clk) trig_int = 1'b1;
    @(negedge clk) trig_int = 1'b0;
    check("lat_int_early", trig_out, 2'b00);
    @(negedge clk);
    out_v  = trig_out;
    strb_v = trig_strb;
  endtask

  task automatic clear_ctr();
    pulse_ctr_rst = 1'b1;
    wait_neg(4);
    check("ctr_clear", pulse_ctr, 0);
    pulse_ctr_rst = 1'b0;
    wait_neg(3);
  endtask

  initial begin
    rst = 1'b1; trig_ext = 1'b0; trig_int = 1'b0; trig_int_en = 1'b1; run = 1'b1;
    trig_rdy = 1'b1; trig_blk = 1'b0; empty_trig_blk = 1'b1; trig_max_cnt = 4'd2;
    trig_seq_sel = {4'd1, 4'd0}; holdoff = 8'd0; pulse_ctr_rst = 1'b0;
    wait_neg(3);
    check("rst_out", trig_out, 0);
    check("rst_strb", trig_strb, 0);
    check("rst_phase", phase, 0);
    check("rst_ctr", pulse_ctr, 0);
    check("rst_pile", pile_up, 0);
    rst = 1'b0;
    wait_neg(4);

    // Case 1: ratio 3, selective fan-out
    for (int i = 0; i < 6; i++) begin
      fire(o, s);
      check("c1_strb", s, exp_s1[i]);
      check("c1_out", o, exp_s1[i]);
    end
    check("c1_ctr", pulse_ctr, 6);
    check("c1_phase", phase, 0);
    check("c1_pile", pile_up, 0);

    // Case 2: every trigger to all channels
    empty_trig_blk = 1'b0;
    wait_neg(3);
    for (int i = 0; i < 3; i++) begin
      fire(o, s);
      check("c2_out", o, 2'b11);
      check("c2_strb", s, exp_s2[i]);
    end
    check("c2_ctr", pulse_ctr, 9);

    // Case 3: blocking until DAQ ready
    trig_blk = 1'b1; trig_rdy = 1'b0;
    wait_neg(3);
    fire(o, s);
    check("c3_first_out", o, 2'b11);
    check("c3_first_strb", s, 2'b01);
    check("c3_pile", pile_up, 1);
    fire(o, s);
    check("c3_blk_out2", o, 2'b00);
    check("c3_blk_strb2", s, 2'b00);
    fire(o, s);
    check("c3_blk_out3", o, 2'b00);
    check("c3_phase", phase, 0);
    check("c3_ctr", pulse_ctr, 12);
    trig_rdy = 1'b1;
    wait_neg(4);
    fire(o, s);
    check("c3_unblk_out", o, 2'b11);
    check("c3_unblk_strb", s, 2'b01);
    check("c3_unblk_pile", pile_up, 0);
    trig_blk = 1'b0; trig_rdy = 1'b0;
    wait_neg(3);
    trig_rdy = 1'b1;
    wait_neg(4);

    // Run low gates outputs but phase and count still advance
    run = 1'b0;
    wait_neg(3);
    fire(o, s);
    check("run_low_out", o, 2'b00);
    check("run_low_strb", s, 2'b00);
    check("run_low_phase", phase, 2);
    check("run_low_ctr", pulse_ctr, 14);
    run = 1'b1;
    wait_neg(3);
    fire(o, s);
    check("run_hi_out", o, 2'b11);
    check("run_hi_strb", s, 2'b00);
    check("run_hi_phase", phase, 0);

    // External source latency: outputs on the fifth edge after first sample
    trig_int_en = 1'b0;
    wait_neg(3);
    trig_ext = 1'b1;
    wait_neg(4);
    check("ext_lat4", trig_out, 2'b00);
    wait_neg(1);
    check("ext_lat5_out", trig_out, 2'b11);
    check("ext_lat5_strb", trig_strb, 2'b01);
    trig_ext = 1'b0; trig_int_en = 1'b1;
    wait_neg(4);
    check("ext_phase", phase, 1);

    // Case 5: counter wrap and clear priority
    clear_ctr();
    for (int i = 0; i < 255; i++) fire(o, s);
    check("c5_ctr_max", pulse_ctr, 255);
    fire(o, s);
    check("c5_ctr_wrap", pulse_ctr, 0);
    fire(o, s);
    fire(o, s);
    check("c5_ctr_two", pulse_ctr, 2);
    pulse_ctr_rst = 1'b1;
    wait_neg(4);
    fire(o, s);
    check("c5_clr_wins", pulse_ctr, 0);
    pulse_ctr_rst = 1'b0;
    wait_neg(3);

    // Case 4: holdoff
    holdoff = 8'd10;
    wait_neg(3);
    fire(o, s);
    wait_neg(2);
    fire(o, s);
`ifdef TRIG_HOLDOFF_EN
    check("c4_ho_drop", pulse_ctr, 1);
`else
    check("c4_no_ho", pulse_ctr, 2);
`endif
    wait_neg(20);
    fire(o, s);
    wait_neg(9);
    fire(o, s);
`ifdef TRIG_HOLDOFF_EN
    check("c4_ho_pass", pulse_ctr, 3);
`else
    check("c4_no_ho_pass", pulse_ctr, 4);
`endif
    holdoff = 8'd0;
    wait_neg(15);

    // Case 6: reset while blocked at phase 3
    rst = 1'b1;
    wait_neg(2);
    rst = 1'b0;
    trig_max_cnt = 4'd4;
    wait_neg(5);
    fire(o, s);
    fire(o, s);
    trig_blk = 1'b1; trig_rdy = 1'b0;
    wait_neg(3);
    fire(o, s);
    check("c6_block_out", o, 2'b11);
    check("c6_phase3", phase, 3);
    wait_neg(2);
    rst = 1'b1;
    #1;
    check("c6_rst_out", trig_out, 0);
    check("c6_rst_strb", trig_strb, 0);
    check("c6_rst_phase", phase, 0);
    check("c6_rst_ctr", pulse_ctr, 0);
    check("c6_rst_pile", pile_up, 0);
    wait_neg(2);
    rst = 1'b0;
    wait_neg(5);
    fire(o, s);
    check("c6_after_out", o, 2'b11);
    check("c6_after_strb", s, 2'b01);
    check("c6_after_phase", phase, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
